// File: rtl/pair_select_combine.sv
// Cursor-driven pair selector: two confirms pick two grid cards, which are
// combined (add / abs-diff / multiply) modulo MOD into a registered result.
module pair_select_combine #(
    parameter int ROWS     = 2,
    parameter int MAX_COLS = 5,
    parameter int W        = 4,
    parameter int MOD      = 10,
    parameter int IW       = $clog2(ROWS*MAX_COLS),
    parameter int CW       = $clog2(MAX_COLS+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CW-1:0]            num,
    input  logic [ROWS*MAX_COLS*W-1:0] status,
    input  logic [3:0]               buttons,
    input  logic                     btn,
    input  logic                     cancel,
    input  logic [1:0]               mode,
    output logic [IW-1:0]            cursor_index,
    output logic [IW:0]              selected_index,
    output logic                     held,
    output logic [W-1:0]             values,
    output logic                     result_valid,
    output logic                     error
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [2*W-1:0] MODV = (2*W)'(MOD);

    typedef enum logic {IDLE, HELD} state_t;

    state_t          state_q, state_nx;
    logic [RW-1:0]   row_q, row_nx, row_prev, row_next;
    logic [CW-1:0]   col_q, col_nx;
    logic [CW-1:0]   n_eff, n_last;
    logic [IW:0]     sel_q, sel_nx;
    logic [W-1:0]    a_q, a_nx, values_q, values_nx;
    logic            rv_q, rv_nx, err_q, err_nx;
    logic [IW-1:0]   cur_idx;
    logic [W-1:0]    cur_val;
    logic [2*W-1:0]  raw, res;

    assign n_eff  = (num == '0) ? CW'(1) : ((num > CW'(MAX_COLS)) ? CW'(MAX_COLS) : num);
    assign n_last = n_eff - CW'(1);

    assign cur_idx  = IW'(row_q) * IW'(MAX_COLS) + IW'(col_q);
    assign cur_val  = status[cur_idx*W +: W];
    assign row_prev = (row_q == '0) ? RW'(ROWS-1) : row_q - RW'(1);
    assign row_next = (row_q == RW'(ROWS-1)) ? '0 : row_q + RW'(1);

    // Operands are widened to 2W so add and multiply never overflow before the modulo.
    always_comb begin
        raw = '0;
        case (mode)
            2'b01:   raw = (a_q >= cur_val) ? (2*W)'(a_q - cur_val) : (2*W)'(cur_val - a_q);
            2'b10:   raw = (2*W)'(a_q) * (2*W)'(cur_val);
            default: raw = (2*W)'(a_q) + (2*W)'(cur_val);
        endcase
        res = raw % MODV;
    end

    always_comb begin
        row_nx = row_q;
        col_nx = col_q;
        if (col_q > n_last) begin
            col_nx = n_last;
        end else if (buttons[0]) begin
            row_nx = row_prev;
        end else if (buttons[1]) begin
            row_nx = row_next;
        end else if (buttons[2]) begin
            if (col_q == '0) begin
                col_nx = n_last;
                row_nx = row_prev;
            end else begin
                col_nx = col_q - CW'(1);
            end
        end else if (buttons[3]) begin
            if (col_q == n_last) begin
                col_nx = '0;
                row_nx = row_next;
            end else begin
                col_nx = col_q + CW'(1);
            end
        end
    end

    // Cancel always swallows a same-cycle confirm.
    always_comb begin
        state_nx  = state_q;
        sel_nx    = sel_q;
        a_nx      = a_q;
        values_nx = values_q;
        rv_nx     = 1'b0;
        err_nx    = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn && !cancel) begin
                    if (cur_val == '0) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx = HELD;
                        sel_nx   = {1'b0, cur_idx};
                        a_nx     = cur_val;
                    end
                end
            end
            HELD: begin
                if (cancel) begin
                    state_nx = IDLE;
                    sel_nx   = '1;
                end else if (btn) begin
                    if ({1'b0, cur_idx} == sel_q) begin
                        state_nx = IDLE;
                        sel_nx   = '1;
                    end else if (cur_val == '0) begin
                        err_nx = 1'b1;
                    end else begin
                        values_nx = res[W-1:0];
                        rv_nx     = 1'b1;
                        state_nx  = IDLE;
                        sel_nx    = '1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                sel_nx   = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            sel_q    <= '1;
            a_q      <= '0;
            values_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            row_q    <= row_nx;
            col_q    <= col_nx;
            sel_q    <= sel_nx;
            a_q      <= a_nx;
            values_q <= values_nx;
            rv_q     <= rv_nx;
            err_q    <= err_nx;
        end
    end

    assign cursor_index   = cur_idx;
    assign selected_index = sel_q;
    assign held           = (state_q == HELD);
    assign values         = values_q;
    assign result_valid   = rv_q;
    assign error          = err_q;
endmodule

// File: tb/tb_pair_select_combine.sv
// Directed bench with a result/error scoreboard for pair_select_combine.
module tb_pair_select_combine;
    localparam int ROWS = 2, MAX_COLS = 5, W = 4, MOD = 10;
    localparam int IW = $clog2(ROWS*MAX_COLS), CW = $clog2(MAX_COLS+1);

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [CW-1:0]             num;
    logic [ROWS*MAX_COLS*W-1:0] status;
    logic [3:0]                buttons;
    logic                      btn, cancel;
    logic [1:0]                mode;
    logic [IW-1:0]             cursor_index;
    logic [IW:0]               selected_index;
    logic                      held;
    logic [W-1:0]              values;
    logic                      result_valid, error;

    typedef struct { logic is_err; logic [W-1:0] val; } exp_t;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    pair_select_combine #(.ROWS(ROWS), .MAX_COLS(MAX_COLS), .W(W), .MOD(MOD)) dut (
        .clk(clk), .rst_n(rst_n), .num(num), .status(status), .buttons(buttons),
        .btn(btn), .cancel(cancel), .mode(mode), .cursor_index(cursor_index),
        .selected_index(selected_index), .held(held), .values(values),
        .result_valid(result_valid), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result or error strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && (result_valid || error)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got rv=%0d err=%0d expected none", result_valid, error);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_kind_err", {31'd0, error}, {31'd0, e.is_err});
                chk("strobe_kind_rv", {31'd0, result_valid}, {31'd0, ~e.is_err});
                if (!e.is_err) chk("values", {28'd0, values}, {28'd0, e.val});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        buttons = 4'b0000;
        btn     = 1'b0;
        cancel  = 1'b0;
    endtask

    task automatic set_cell(input int k, input logic [W-1:0] v);
        status[k*W +: W] = v;
    endtask

    task automatic goto_idx(input int t);
        int n = 0;
        while (cursor_index != IW'(t) && n < 20) begin
            buttons = 4'b1000;
            tick();
            n++;
        end
        chk("goto", {28'd0, cursor_index}, t);
    endtask

    task automatic confirm();
        btn = 1'b1;
        tick();
    endtask

    task automatic do_pair(input int i, input int j, input logic [1:0] m, input logic [W-1:0] r);
        goto_idx(i);
        confirm();
        chk("pair_held", {31'd0, held}, 1);
        chk("pair_sel", {27'd0, selected_index}, i);
        goto_idx(j);
        mode = m;
        exp_q.push_back('{is_err: 1'b0, val: r});
        confirm();
        chk("pair_idle", {31'd0, held}, 0);
        chk("pair_sel_clear", {27'd0, selected_index}, 31);
        chk("pair_values", {28'd0, values}, {28'd0, r});
    endtask

    initial begin
        rst_n = 1'b0; num = CW'(5); status = '0; buttons = '0;
        btn = 1'b0; cancel = 1'b0; mode = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cursor", {28'd0, cursor_index}, 0);
        chk("rst_sel", {27'd0, selected_index}, 31);
        chk("rst_held", {31'd0, held}, 0);
        chk("rst_values", {28'd0, values}, 0);
        chk("rst_rv", {31'd0, result_valid}, 0);
        chk("rst_err", {31'd0, error}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cursor walk
        for (int i = 1; i <= 5; i++) begin
            buttons = 4'b1000;
            tick();
            chk("right_walk", {28'd0, cursor_index}, i);
        end
        goto_idx(0);
        buttons = 4'b0100; tick();
        chk("left_wrap", {28'd0, cursor_index}, 9);
        goto_idx(2);
        buttons = 4'b0001; tick();
        chk("up_wrap", {28'd0, cursor_index}, 7);

        // Combine modes
        set_cell(1, 4'd7); set_cell(8, 4'd6);
        do_pair(1, 8, 2'b00, 4'd3);
        set_cell(1, 4'd3); set_cell(8, 4'd9);
        do_pair(1, 8, 2'b01, 4'd6);
        set_cell(1, 4'd7); set_cell(8, 4'd8);
        do_pair(1, 8, 2'b10, 4'd6);
        set_cell(1, 4'd15); set_cell(8, 4'd15);
        do_pair(1, 8, 2'b10, 4'd5);
        do_pair(8, 1, 2'b00, 4'd0);
        set_cell(1, 4'd9); set_cell(8, 4'd8);
        do_pair(8, 1, 2'b01, 4'd1);

        // Held value is the one latched at the first pick
        set_cell(1, 4'd4); set_cell(8, 4'd9);
        goto_idx(1);
        confirm();
        set_cell(1, 4'd9); set_cell(8, 4'd4);
        goto_idx(8);
        mode = 2'b11;
        exp_q.push_back('{is_err: 1'b0, val: 4'd8});
        confirm();
        chk("latched_values", {28'd0, values}, 8);

        // Empty cell in IDLE
        set_cell(3, 4'd0);
        goto_idx(3);
        exp_q.push_back('{is_err: 1'b1, val: 4'd0});
        confirm();
        chk("empty_idle_held", {31'd0, held}, 0);

        // Empty cell while HELD, then cancel
        goto_idx(8);
        confirm();
        goto_idx(3);
        exp_q.push_back('{is_err: 1'b1, val: 4'd0});
        confirm();
        chk("empty_held_stays", {31'd0, held}, 1);
        chk("empty_held_sel", {27'd0, selected_index}, 8);
        cancel = 1'b1; tick();
        chk("cancel_held", {31'd0, held}, 0);

        // Same cell twice, back-to-back
        goto_idx(8);
        confirm();
        confirm();
        chk("deselect_held", {31'd0, held}, 0);
        chk("deselect_sel", {27'd0, selected_index}, 31);
        chk("deselect_values", {28'd0, values}, 8);

        // btn and cancel together
        goto_idx(1);
        confirm();
        goto_idx(8);
        btn = 1'b1; cancel = 1'b1; tick();
        chk("btncancel_held", {31'd0, held}, 0);
        chk("btncancel_sel", {27'd0, selected_index}, 31);
        chk("btncancel_values", {28'd0, values}, 8);

        // Asynchronous reset mid-hold
        goto_idx(1);
        confirm();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("arst_held", {31'd0, held}, 0);
        chk("arst_sel", {27'd0, selected_index}, 31);
        chk("arst_cursor", {28'd0, cursor_index}, 0);
        chk("arst_values", {28'd0, values}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Column snap when num shrinks, and num=0 as 1
        goto_idx(4);
        num = CW'(3);
        buttons = 4'b1000; tick();
        chk("snap_col", {28'd0, cursor_index}, 2);
        num = CW'(0);
        tick();
        chk("snap_num0", {28'd0, cursor_index}, 0);
        buttons = 4'b1000; tick();
        chk("num0_right", {28'd0, cursor_index}, MAX_COLS);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
